// File: rtl/bus_watchdog.sv
// Bus-transaction watchdog: releases a hung access with a one-cycle synthetic ready and raises a sticky irq.
// Define BUS_WDT_ERR_LOG_EN to build the err_addr / err_rw / err_cnt failure log; otherwise those ports read 0.
module bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8,
  parameter int ADDR_W         = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wdt_en,
  input  logic              bus_as_n,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_rw,
  input  logic              slv_rdy_n,
  output logic              wdt_rdy_n,
  output logic              wdt_err,
  output logic              irq,
  input  logic              irq_clr,
  output logic [ADDR_W-1:0] err_addr,
  output logic              err_rw,
  output logic [7:0]        err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             wdt_rdy_n_reg, wdt_rdy_n_next;
  logic             wdt_err_reg, wdt_err_next;
  logic             irq_reg, irq_next;
  logic             abort_fire;

  // State, wait counter and the registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      wdt_rdy_n_reg <= 1'b1;
      wdt_err_reg   <= 1'b0;
      irq_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      wdt_rdy_n_reg <= wdt_rdy_n_next;
      wdt_err_reg   <= wdt_err_next;
      irq_reg       <= irq_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (!wdt_en) begin
      // Disabling drops any access in flight, including one about to abort
      state_next = ST_IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!bus_as_n && slv_rdy_n) begin
            state_next = ST_WAIT;
            cnt_next   = CNT_ONE;
          end
        end
        ST_WAIT: begin
          if (!slv_rdy_n || bus_as_n) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end else if (cnt_reg == TIMEOUT_VAL) begin
            state_next = ST_ABORT;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        ST_ABORT: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    abort_fire     = (state_reg == ST_WAIT) && (state_next == ST_ABORT);
    wdt_rdy_n_next = ~abort_fire;
    wdt_err_next   = abort_fire;
    irq_next       = irq_reg;
    // A new abort outranks a clear landing on the same edge
    if (abort_fire) begin
      irq_next = 1'b1;
    end else if (irq_clr) begin
      irq_next = 1'b0;
    end
  end

  assign wdt_rdy_n = wdt_rdy_n_reg;
  assign wdt_err   = wdt_err_reg;
  assign irq       = irq_reg;

`ifdef BUS_WDT_ERR_LOG_EN
  logic [ADDR_W-1:0] err_addr_reg;
  logic              err_rw_reg;
  logic [7:0]        err_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_addr_reg <= '0;
      err_rw_reg   <= 1'b0;
      err_cnt_reg  <= '0;
    end else if (abort_fire) begin
      err_addr_reg <= bus_addr;
      err_rw_reg   <= bus_rw;
      if (err_cnt_reg != 8'hFF) begin
        err_cnt_reg <= err_cnt_reg + 8'd1;
      end
    end
  end

  assign err_addr = err_addr_reg;
  assign err_rw   = err_rw_reg;
  assign err_cnt  = err_cnt_reg;
`else
  logic unused_log_inputs;
  assign unused_log_inputs = ^{bus_addr, bus_rw};

  assign err_addr = '0;
  assign err_rw   = 1'b0;
  assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_bus_watchdog.sv
// Self-checking bench for bus_watchdog with TIMEOUT_CYCLES=4: directed scenarios plus randomized accesses
// against a transaction-level model (abort iff neither ready nor release arrives by access edge T+1).
module tb_bus_watchdog;

  localparam int T      = 4;
  localparam int ADDR_W = 30;
`ifdef BUS_WDT_ERR_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              wdt_en;
  logic              bus_as_n;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_rw;
  logic              slv_rdy_n;
  logic              wdt_rdy_n;
  logic              wdt_err;
  logic              irq;
  logic              irq_clr;
  logic [ADDR_W-1:0] err_addr;
  logic              err_rw;
  logic [7:0]        err_cnt;

  bus_watchdog #(
    .TIMEOUT_CYCLES(T),
    .CNT_W(8),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wdt_en(wdt_en),
    .bus_as_n(bus_as_n),
    .bus_addr(bus_addr),
    .bus_rw(bus_rw),
    .slv_rdy_n(slv_rdy_n),
    .wdt_rdy_n(wdt_rdy_n),
    .wdt_err(wdt_err),
    .irq(irq),
    .irq_clr(irq_clr),
    .err_addr(err_addr),
    .err_rw(err_rw),
    .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: architectural state seen by the CPU
  logic              exp_irq;
  int                exp_err_cnt;
  logic [ADDR_W-1:0] exp_err_addr;
  logic              exp_err_rw;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_irq      = 1'b0;
    exp_err_cnt  = 0;
    exp_err_addr = '0;
    exp_err_rw   = 1'b0;
  endtask

  task automatic check_log();
    logic [31:0] want_addr;
    logic [31:0] want_rw;
    logic [31:0] want_cnt;
    want_addr = LOG_EN ? 32'(exp_err_addr) : 32'd0;
    want_rw   = LOG_EN ? 32'(exp_err_rw) : 32'd0;
    want_cnt  = LOG_EN ? 32'(exp_err_cnt) : 32'd0;
    check("err_addr", 32'(err_addr), want_addr);
    check("err_rw", 32'(err_rw), want_rw);
    check("err_cnt", 32'(err_cnt), want_cnt);
    check("irq_log", 32'(irq), 32'(exp_irq));
  endtask

  task automatic idle_cycle(input logic clr);
    bus_as_n  = 1'b1;
    slv_rdy_n = 1'b1;
    irq_clr   = clr;
    @(posedge clk);
    @(negedge clk);
    if (clr) exp_irq = 1'b0;
    irq_clr = 1'b0;
    check("idle_rdy_n", 32'(wdt_rdy_n), 32'd1);
    check("idle_err", 32'(wdt_err), 32'd0);
    check("idle_irq", 32'(irq), 32'(exp_irq));
  endtask

  // One master access. Edge numbers count from the first edge that samples the strobe low.
  // rdy_edge: edge sampling slave ready (0 = never); abandon_edge: edge sampling the strobe
  // released without ready (0 = never); clr_edge: edge sampling irq_clr (0 = none).
  task automatic run_access(input logic [ADDR_W-1:0] addr, input logic rw,
                            input int rdy_edge, input int abandon_edge, input int clr_edge);
    bit aborts;
    int abort_edge;
    int last_edge;
    aborts = !((rdy_edge >= 1 && rdy_edge <= T + 1) ||
               (abandon_edge >= 1 && abandon_edge <= T + 1));
    abort_edge = aborts ? T + 1 : -1;
    last_edge  = 0;
    for (int e = 1; e <= T + 2; e++) begin
      bus_addr  = addr;
      bus_rw    = rw;
      bus_as_n  = (abandon_edge != 0 && e >= abandon_edge);
      slv_rdy_n = (e != rdy_edge);
      irq_clr   = (e == clr_edge);
      @(posedge clk);
      @(negedge clk);
      if (e == abort_edge) begin
        exp_irq      = 1'b1;
        exp_err_cnt  = (exp_err_cnt < 255) ? exp_err_cnt + 1 : 255;
        exp_err_addr = addr;
        exp_err_rw   = rw;
      end else if (e == clr_edge) begin
        exp_irq = 1'b0;
      end
      check("wdt_rdy_n", 32'(wdt_rdy_n), (e == abort_edge) ? 32'd0 : 32'd1);
      check("wdt_err", 32'(wdt_err), (e == abort_edge) ? 32'd1 : 32'd0);
      check("irq", 32'(irq), 32'(exp_irq));
      last_edge = e;
      if (e == rdy_edge || e == abandon_edge || e == abort_edge + 1) break;
    end
    bus_as_n  = 1'b1;
    slv_rdy_n = 1'b1;
    irq_clr   = 1'b0;
    check_log();
    $display("access addr=0x%08h rw=%0d rdy_edge=%0d abandon=%0d clr=%0d edges=%0d abort=%0d err_cnt=%0d",
             addr, rw, rdy_edge, abandon_edge, clr_edge, last_edge, aborts, err_cnt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int drop;
    int rdy;
    int aband;
    int clr;
    logic [ADDR_W-1:0] a;
    logic r;

    reset     = 1'b1;
    wdt_en    = 1'b1;
    bus_as_n  = 1'b1;
    bus_addr  = '0;
    bus_rw    = 1'b0;
    slv_rdy_n = 1'b1;
    irq_clr   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rdy_n", 32'(wdt_rdy_n), 32'd1);
    check("rst_err", 32'(wdt_err), 32'd0);
    check_log();
    reset = 1'b0;
    idle_cycle(1'b0);

    // Slave ready in wait cycle 2, then a full timeout, then ready coincident with ABORT
    run_access(30'h100, 1'b0, 3, 0, 0);
    run_access(30'h2A5, 1'b1, 0, 0, 0);
    run_access(30'h3C0, 1'b0, T + 2, 0, 0);
    idle_cycle(1'b0);

    // irq_clr on the abort edge loses; a lone clear afterwards wins
    run_access(30'h055, 1'b1, 0, 0, T + 1);
    idle_cycle(1'b1);
    idle_cycle(1'b0);

    // wdt_en dropped mid-wait and on the would-be abort edge; the re-enabled access starts fresh
    for (int k = 0; k < 2; k++) begin
      drop = (k == 0) ? 3 : T + 1;
      for (int e = 1; e <= T + 3; e++) begin
        bus_addr  = 30'h1234;
        bus_rw    = 1'b0;
        bus_as_n  = 1'b0;
        slv_rdy_n = 1'b1;
        wdt_en    = (e < drop);
        @(posedge clk);
        @(negedge clk);
        check("en_rdy_n", 32'(wdt_rdy_n), 32'd1);
        check("en_err", 32'(wdt_err), 32'd0);
      end
      wdt_en = 1'b1;
      run_access(30'h1234, 1'b0, 0, 0, 0);
      $display("wdt_en drop at edge %0d done", drop);
    end

    // Reset during the ABORT cycle
    for (int e = 1; e <= T + 1; e++) begin
      bus_addr  = 30'h0ABC;
      bus_rw    = 1'b1;
      bus_as_n  = 1'b0;
      slv_rdy_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    check("pre_rst_rdy_n", 32'(wdt_rdy_n), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    check("abort_rst_rdy_n", 32'(wdt_rdy_n), 32'd1);
    check("abort_rst_err", 32'(wdt_err), 32'd0);
    check_log();
    reset    = 1'b0;
    bus_as_n = 1'b1;
    idle_cycle(1'b0);

    // Randomized accesses, some back-to-back
    for (int n = 0; n < 200; n++) begin
      a     = ADDR_W'($urandom);
      r     = 1'($urandom);
      rdy   = int'($urandom_range(0, T + 3));
      aband = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, T + 1)) : 0;
      clr   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, T + 2)) : 0;
      run_access(a, r, rdy, aband, clr);
      if ($urandom_range(0, 2) == 0) idle_cycle(1'($urandom));
    end

    // Back-to-back timeouts drive the log counter into saturation
    for (int n = 0; n < 300; n++) begin
      run_access(ADDR_W'(n), 1'(n), 0, 0, 0);
    end
    idle_cycle(1'b0);
    check("sat_err_cnt", 32'(err_cnt), LOG_EN ? 32'd255 : 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
